// File: rtl/wb_p_pkg.sv
// Shared types and elaboration helpers for the Wishbone pipelined bridge.
// req_t describes the default 32/32/8 request tuple; wider instances build their own.
package wb_p_pkg;

   localparam int DEF_DATA_WIDTH  = 32;
   localparam int DEF_ADDR_WIDTH  = 32;
   localparam int DEF_GRANULARITY = 8;
   localparam int DEF_SEL_WIDTH   = DEF_DATA_WIDTH / DEF_GRANULARITY;
   localparam int DEF_MAX_OUT     = 8;

   typedef struct packed {
      logic [DEF_ADDR_WIDTH-1:0] adr;
      logic [DEF_DATA_WIDTH-1:0] dat;
      logic                      we;
      logic [DEF_SEL_WIDTH-1:0]  sel;
   } req_t;

   function automatic bit gran_ok(input int gran);
      return (gran == 8) || (gran == 16) || (gran == 32);
   endfunction

   // One extra bit so the counter can hold MAX_OUTSTANDING itself.
   function automatic int cnt_width(input int max_out);
      return $clog2(max_out) + 1;
   endfunction

   localparam int DEF_CNT_WIDTH = cnt_width(DEF_MAX_OUT);

endpackage

// File: rtl/wb_p_skid_buf.sv
// Two-entry skid buffer: output register plus one skid slot; 1-cycle latency.
// in_rdy is a flop (skid empty), so upstream stall never sees a downstream combinational path.
module wb_p_skid_buf import wb_p_pkg::*; #(
   parameter type T = req_t
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic flush,
   input  logic in_vld,
   input  T     in_dat,
   output logic in_rdy,
   output logic out_vld,
   output T     out_dat,
   input  logic out_rdy
);

   logic skid_vld;
   T     skid_dat;
   logic take;

   assign in_rdy = !skid_vld;
   assign take   = in_vld && in_rdy;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_vld  <= 1'b0;
         skid_vld <= 1'b0;
         out_dat  <= '0;
         skid_dat <= '0;
      end else if (flush) begin
         out_vld  <= 1'b0;
         skid_vld <= 1'b0;
      end else if (out_vld && out_rdy) begin
         if (skid_vld) begin
            out_dat  <= skid_dat;
            skid_vld <= 1'b0;
         end else if (take) begin
            out_dat <= in_dat;
         end else begin
            out_vld <= 1'b0;
         end
      end else if (take) begin
         // OUT is blocked: park the new request in the skid slot.
         if (!out_vld) begin
            out_dat <= in_dat;
            out_vld <= 1'b1;
         end else begin
            skid_dat <= in_dat;
            skid_vld <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_p_pipe_bridge.sv
// Registered Wishbone B4 pipelined stage: requests and responses each take one cycle.
// Upstream stalls once the skid slot fills; downstream issue is capped at MAX_OUTSTANDING.
module wb_p_pipe_bridge import wb_p_pkg::*; #(
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 32,
   parameter int GRANULARITY     = 8,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [ADDR_WIDTH-1:0]             s_adr,
   input  logic [DATA_WIDTH-1:0]             s_dat_i,
   input  logic                              s_we,
   input  logic [DATA_WIDTH/GRANULARITY-1:0] s_sel,
   input  logic                              s_stb,
   input  logic                              s_cyc,
   output logic [DATA_WIDTH-1:0]             s_dat_o,
   output logic                              s_ack,
   output logic                              s_stall,
   output logic [ADDR_WIDTH-1:0]             m_adr,
   output logic [DATA_WIDTH-1:0]             m_dat_o,
   output logic                              m_we,
   output logic [DATA_WIDTH/GRANULARITY-1:0] m_sel,
   output logic                              m_stb,
   output logic                              m_cyc,
   input  logic [DATA_WIDTH-1:0]             m_dat_i,
   input  logic                              m_ack,
   input  logic                              m_stall
);

   localparam int SEL_WIDTH = DATA_WIDTH / GRANULARITY;
   localparam int CNT_WIDTH = cnt_width(MAX_OUTSTANDING);

   if (!gran_ok(GRANULARITY)) begin : g_bad_gran
      $fatal(1, "wb_p_pipe_bridge: GRANULARITY must be 8, 16 or 32");
   end
   if (MAX_OUTSTANDING < 2 || (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0) begin : g_bad_max
      $fatal(1, "wb_p_pipe_bridge: MAX_OUTSTANDING must be a power of 2, at least 2");
   end

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] adr;
      logic [DATA_WIDTH-1:0] dat;
      logic                  we;
      logic [SEL_WIDTH-1:0]  sel;
   } bus_req_t;

   bus_req_t             in_req;
   bus_req_t             out_req;
   logic                 in_rdy;
   logic                 out_vld;
   logic                 below_max;
   logic                 issue;
   logic                 ack_cnt;
   logic [CNT_WIDTH-1:0] cnt;

   assign in_req    = '{adr: s_adr, dat: s_dat_i, we: s_we, sel: s_sel};
   assign below_max = cnt < CNT_WIDTH'(MAX_OUTSTANDING);
   assign issue     = m_stb && !m_stall;
   // Acks only count while a request is outstanding on a live downstream cycle.
   assign ack_cnt   = m_ack && m_cyc && (cnt != '0);

   wb_p_skid_buf #(.T(bus_req_t)) u_skid (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush   (!s_cyc),
      .in_vld  (s_cyc && s_stb),
      .in_dat  (in_req),
      .in_rdy  (in_rdy),
      .out_vld (out_vld),
      .out_dat (out_req),
      .out_rdy (below_max && !m_stall)
   );

   assign s_stall = !in_rdy;
   assign m_stb   = out_vld && below_max;
   assign m_adr   = out_req.adr;
   assign m_dat_o = out_req.dat;
   assign m_we    = out_req.we;
   assign m_sel   = out_req.sel;

   always_ff @(posedge clk_i) begin
      if (rst_i || !s_cyc) begin
         cnt <= '0;
      end else if (issue && !ack_cnt) begin
         cnt <= cnt + CNT_WIDTH'(1);
      end else if (!issue && ack_cnt) begin
         cnt <= cnt - CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         m_cyc   <= 1'b0;
         s_ack   <= 1'b0;
         s_dat_o <= '0;
      end else begin
         m_cyc <= s_cyc;
         s_ack <= ack_cnt && s_cyc;
         if (ack_cnt) begin
            s_dat_o <= m_dat_i;
         end
      end
   end

endmodule

// File: tb/tb_wb_p_pipe_bridge.sv
// Directed bench for wb_p_pipe_bridge: inputs change 1 time unit after posedge,
// outputs are compared at that same point, so each step shows the result of one edge.
module tb_wb_p_pipe_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] s_adr, s_dat_i, s_dat_o, m_adr, m_dat_o, m_dat_i;
   logic [3:0]  s_sel, m_sel;
   logic        s_we, s_stb, s_cyc, s_ack, s_stall;
   logic        m_we, m_stb, m_cyc, m_ack, m_stall;

   int          checks = 0;
   int          errors = 0;
   int          n_ack;
   int          n_stall;
   logic [31:0] iss_adr [$];

   always #5 clk = ~clk;

   wb_p_pipe_bridge #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .GRANULARITY(8), .MAX_OUTSTANDING(8)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .s_adr(s_adr), .s_dat_i(s_dat_i), .s_we(s_we), .s_sel(s_sel),
      .s_stb(s_stb), .s_cyc(s_cyc), .s_dat_o(s_dat_o), .s_ack(s_ack), .s_stall(s_stall),
      .m_adr(m_adr), .m_dat_o(m_dat_o), .m_we(m_we), .m_sel(m_sel),
      .m_stb(m_stb), .m_cyc(m_cyc), .m_dat_i(m_dat_i), .m_ack(m_ack), .m_stall(m_stall)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic stb, input logic [31:0] adr, input logic [31:0] dat,
                        input logic we, input logic [3:0] sel);
      s_stb   = stb;
      s_adr   = adr;
      s_dat_i = dat;
      s_we    = we;
      s_sel   = sel;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_m_stb"},   64'(m_stb),   64'h0);
      chk({tag, "_m_cyc"},   64'(m_cyc),   64'h0);
      chk({tag, "_m_adr"},   64'(m_adr),   64'h0);
      chk({tag, "_m_dat"},   64'(m_dat_o), 64'h0);
      chk({tag, "_m_we"},    64'(m_we),    64'h0);
      chk({tag, "_m_sel"},   64'(m_sel),   64'h0);
      chk({tag, "_s_ack"},   64'(s_ack),   64'h0);
      chk({tag, "_s_dat"},   64'(s_dat_o), 64'h0);
      chk({tag, "_s_stall"}, 64'(s_stall), 64'h0);
   endtask

   initial begin
      // Reset
      rst = 1'b1; s_cyc = 1'b0; m_dat_i = '0; m_ack = 1'b0; m_stall = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
      step(); step();
      chk_all_zero("rst");
      rst = 1'b0;

      // Single read
      s_cyc = 1'b1;
      drive(1'b1, 32'h100, 32'h0, 1'b0, 4'hF);
      step();
      chk("rd_m_stb", 64'(m_stb), 64'h1);
      chk("rd_m_adr", 64'(m_adr), 64'h100);
      chk("rd_m_we",  64'(m_we),  64'h0);
      chk("rd_m_cyc", 64'(m_cyc), 64'h1);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 4'hF);
      step();
      chk("rd_issued", 64'(m_stb), 64'h0);
      chk("rd_no_ack", 64'(s_ack), 64'h0);
      m_ack = 1'b1; m_dat_i = 32'hDEADBEEF;
      step();
      chk("rd_s_ack", 64'(s_ack),   64'h1);
      chk("rd_s_dat", 64'(s_dat_o), 64'hDEADBEEF);
      m_ack = 1'b0; m_dat_i = 32'h0;
      step();
      chk("rd_ack_drop", 64'(s_ack),   64'h0);
      chk("rd_dat_hold", 64'(s_dat_o), 64'hDEADBEEF);

      // Back-to-back burst of 8 writes, slave acks one cycle after each issue
      n_ack = 0; n_stall = 0;
      for (int c = 0; c < 12; c++) begin
         drive(c < 8, 32'(c * 4), 32'(32'hA0 + c), 1'b1, 4'hF);
         m_ack   = (c >= 2 && c < 10);
         m_dat_i = (c >= 2) ? 32'(32'h500 + c - 2) : 32'h0;
         step();
         chk("bu_m_stb", 64'(m_stb), 64'(c < 8));
         if (c < 8) begin
            chk("bu_m_adr", 64'(m_adr),   64'(c * 4));
            chk("bu_m_dat", 64'(m_dat_o), 64'(32'hA0 + c));
         end
         chk("bu_s_ack", 64'(s_ack), 64'(c >= 2 && c < 10));
         if (c >= 2 && c < 10) chk("bu_s_dat", 64'(s_dat_o), 64'(32'h500 + c - 2));
         if (s_ack) n_ack++;
         if (s_stall) n_stall++;
      end
      chk("bu_ack_total",   64'(n_ack),   64'd8);
      chk("bu_stall_total", 64'(n_stall), 64'd0);

      // Downstream stall during a 4-request burst
      m_ack = 1'b0; m_stall = 1'b1;
      drive(1'b1, 32'h40, 32'hC0, 1'b1, 4'hF);
      step();
      chk("st_r0_stb",   64'(m_stb),   64'h1);
      chk("st_r0_adr",   64'(m_adr),   64'h40);
      chk("st_r0_stall", 64'(s_stall), 64'h0);
      drive(1'b1, 32'h44, 32'hC1, 1'b1, 4'h3);
      step();
      chk("st_skid_stall", 64'(s_stall), 64'h1);
      chk("st_skid_adr",   64'(m_adr),   64'h40);
      drive(1'b1, 32'h48, 32'hC2, 1'b1, 4'hF);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("st_hold_stall", 64'(s_stall), 64'h1);
         chk("st_hold_adr",   64'(m_adr),   64'h40);
         chk("st_hold_stb",   64'(m_stb),   64'h1);
      end
      m_stall = 1'b0;
      step();
      chk("st_r1_adr",   64'(m_adr),   64'h44);
      chk("st_r1_sel",   64'(m_sel),   64'h3);
      chk("st_r1_dat",   64'(m_dat_o), 64'hC1);
      chk("st_r1_stall", 64'(s_stall), 64'h0);
      step();
      chk("st_r2_adr", 64'(m_adr), 64'h48);
      chk("st_r2_dat", 64'(m_dat_o), 64'hC2);
      drive(1'b1, 32'h4C, 32'hC3, 1'b1, 4'hF);
      step();
      chk("st_r3_adr", 64'(m_adr), 64'h4C);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 4'hF);
      step();
      chk("st_drained", 64'(m_stb), 64'h0);
      for (int k = 0; k < 4; k++) begin
         m_ack = 1'b1; m_dat_i = 32'(32'h600 + k);
         step();
         chk("st_s_ack", 64'(s_ack),   64'h1);
         chk("st_s_dat", 64'(s_dat_o), 64'(32'h600 + k));
      end
      m_ack = 1'b0;
      step();
      chk("st_ack_end", 64'(s_ack), 64'h0);

      // Outstanding limit: slave withholds acks while 10 requests are offered
      iss_adr.delete();
      for (int c = 0; c < 10; c++) begin
         drive(1'b1, 32'(32'h1000 + c * 4), 32'(c), 1'b1, 4'hF);
         step();
         if (m_stb) iss_adr.push_back(m_adr);
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 4'hF);
      for (int c = 0; c < 2; c++) begin
         step();
         if (m_stb) iss_adr.push_back(m_adr);
      end
      chk("lim_issued", 64'(iss_adr.size()), 64'd8);
      chk("lim_stb",    64'(m_stb),          64'h0);
      chk("lim_stall",  64'(s_stall),        64'h1);
      chk("lim_head",   64'(m_adr),          64'h1020);
      n_ack = 0;
      for (int k = 0; k < 10; k++) begin
         m_ack = 1'b1; m_dat_i = 32'(32'h700 + k);
         step();
         if (m_stb) iss_adr.push_back(m_adr);
         if (s_ack) n_ack++;
      end
      m_ack = 1'b0;
      step();
      chk("lim_total", 64'(iss_adr.size()), 64'd10);
      if (iss_adr.size() == 10) begin
         chk("lim_q7", 64'(iss_adr[7]), 64'h101C);
         chk("lim_q8", 64'(iss_adr[8]), 64'h1020);
         chk("lim_q9", 64'(iss_adr[9]), 64'h1024);
      end
      chk("lim_acks",  64'(n_ack),   64'd10);
      chk("lim_s_dat", 64'(s_dat_o), 64'h709);

      // Abort with 3 outstanding
      for (int c = 0; c < 3; c++) begin
         drive(1'b1, 32'(32'h2000 + c * 4), 32'h0, 1'b0, 4'hF);
         step();
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 4'hF);
      step();
      chk("ab_pre_cyc", 64'(m_cyc), 64'h1);
      s_cyc = 1'b0;
      step();
      chk("ab_m_cyc", 64'(m_cyc), 64'h0);
      chk("ab_m_stb", 64'(m_stb), 64'h0);
      m_ack = 1'b1; m_dat_i = 32'hBAD;
      step();
      chk("ab_late_ack0", 64'(s_ack), 64'h0);
      s_cyc = 1'b1;
      step();
      chk("ab_late_ack1", 64'(s_ack),   64'h0);
      chk("ab_dat_hold",  64'(s_dat_o), 64'h709);
      m_ack = 1'b0;
      drive(1'b1, 32'h300, 32'h0, 1'b0, 4'hF);
      step();
      chk("ab_new_stb", 64'(m_stb), 64'h1);
      chk("ab_new_adr", 64'(m_adr), 64'h300);
      chk("ab_new_cyc", 64'(m_cyc), 64'h1);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 4'hF);
      step();
      m_ack = 1'b1; m_dat_i = 32'h12345678;
      step();
      chk("ab_new_ack", 64'(s_ack),   64'h1);
      chk("ab_new_dat", 64'(s_dat_o), 64'h12345678);
      m_dat_i = 32'h55;
      step();
      chk("ab_spur_ack", 64'(s_ack),   64'h0);
      chk("ab_spur_dat", 64'(s_dat_o), 64'h12345678);
      m_ack = 1'b0;
      drive(1'b1, 32'h304, 32'h0, 1'b0, 4'hF);
      step();
      chk("ab_no_underflow", 64'(m_stb), 64'h1);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 4'hF);
      step();
      m_ack = 1'b1; m_dat_i = 32'h66;
      step();
      chk("ab_post_ack", 64'(s_ack), 64'h1);
      m_ack = 1'b0;
      step();

      // Reset while OUT and SKID are both full
      m_stall = 1'b1;
      drive(1'b1, 32'h3000, 32'h11, 1'b1, 4'hF);
      step();
      drive(1'b1, 32'h3004, 32'h22, 1'b1, 4'hF);
      step();
      chk("rm_skid_full", 64'(s_stall), 64'h1);
      rst = 1'b1;
      step();
      chk_all_zero("rm");
      rst = 1'b0; m_stall = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 4'hF);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("rm_no_stale", 64'(m_stb), 64'h0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
